// File: rtl/ccc_apb_cfg_master.sv
// ccc_apb_cfg_master
//
// APB initiator for the dynamic-configuration port of the fabric CCC.
// The block takes one register read or write command at a time from fabric
// control logic. It waits for the CCC to drop BUSY and then runs a single
// zero-wait-state APB setup/access transfer. After a write it can wait for
// the PLL to re-lock. It then returns a one-cycle response with status and
// read data.
//
// Ports
//   PCLK, PRESET_N      fabric clock (rising edge), synchronous active-low reset
//   cmd_valid/ready     command handshake; ready only while idle
//   cmd_write           1 = write, 0 = read
//   cmd_addr/wdata      register address and write data
//   cmd_wait_lock       after a write, wait for a stable LOCK before responding
//   rsp_valid           one-cycle response pulse (no backpressure)
//   rsp_rdata           read data (0 for writes and errors)
//   rsp_err             00 ok, 01 BUSY timeout, 10 LOCK timeout
//   lock_lost           sticky flag: LOCK fell while not waiting for re-lock
//   lock_lost_clr       clears lock_lost (a simultaneous new fall wins)
//   PSEL..PWDATA        APB request outputs to the CCC
//   PRDATA, BUSY, LOCK  APB read data, CCC busy and PLL lock inputs
module ccc_apb_cfg_master #(
    parameter int ADDR_W       = 6,
    parameter int DATA_W       = 8,
    parameter int BUSY_TIMEOUT = 256,
    parameter int LOCK_TIMEOUT = 4096,
    parameter int LOCK_STABLE  = 4
) (
    input  logic              PCLK,
    input  logic              PRESET_N,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    input  logic              cmd_wait_lock,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [1:0]        rsp_err,
    output logic              lock_lost,
    input  logic              lock_lost_clr,
    output logic              PSEL,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [ADDR_W-1:0] PADDR,
    output logic [DATA_W-1:0] PWDATA,
    input  logic [DATA_W-1:0] PRDATA,
    input  logic              BUSY,
    input  logic              LOCK
);

    localparam int BUSY_CNT_W = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;
    localparam int LOCK_CNT_W = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;
    localparam int STABLE_W   = (LOCK_STABLE  > 1) ? $clog2(LOCK_STABLE)  : 1;

    // Terminal counts: each counter stops at its last value and never wraps.
    localparam logic [BUSY_CNT_W-1:0] BUSY_LAST   = BUSY_CNT_W'(BUSY_TIMEOUT - 1);
    localparam logic [LOCK_CNT_W-1:0] LOCK_LAST   = LOCK_CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [STABLE_W-1:0]   STABLE_LAST = STABLE_W'(LOCK_STABLE - 1);

    localparam logic [1:0] ERR_OK   = 2'b00;
    localparam logic [1:0] ERR_BUSY = 2'b01;
    localparam logic [1:0] ERR_LOCK = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_BUSY,
        SETUP,
        ACCESS,
        WAIT_LOCK,
        RESP
    } state_e;

    state_e              state_q, state_d;
    logic                write_q, write_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                wait_lock_q, wait_lock_d;
    logic [BUSY_CNT_W-1:0] busy_cnt_q, busy_cnt_d;
    logic [LOCK_CNT_W-1:0] lock_cnt_q, lock_cnt_d;
    logic [STABLE_W-1:0] stable_q, stable_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic [1:0]          err_q, err_d;
    logic                lock_hist_q;
    logic                lock_lost_q, lock_lost_d;

    // State and datapath registers. Reset returns to IDLE, which immediately
    // drops any APB transfer in flight and discards its response.
    always_ff @(posedge PCLK) begin
        if (!PRESET_N) begin
            state_q     <= IDLE;
            write_q     <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wait_lock_q <= 1'b0;
            busy_cnt_q  <= '0;
            lock_cnt_q  <= '0;
            stable_q    <= '0;
            rdata_q     <= '0;
            err_q       <= ERR_OK;
            lock_hist_q <= 1'b0;
            lock_lost_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            write_q     <= write_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wait_lock_q <= wait_lock_d;
            busy_cnt_q  <= busy_cnt_d;
            lock_cnt_q  <= lock_cnt_d;
            stable_q    <= stable_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
            lock_hist_q <= LOCK;
            lock_lost_q <= lock_lost_d;
        end
    end

    // Next-state logic. A falling LOCK is expected while the PLL re-locks
    // after a write, so only falls outside WAIT_LOCK raise lock_lost; a new
    // fall takes priority over a clear in the same cycle.
    always_comb begin
        state_d     = state_q;
        write_d     = write_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wait_lock_d = wait_lock_q;
        busy_cnt_d  = busy_cnt_q;
        lock_cnt_d  = lock_cnt_q;
        stable_d    = stable_q;
        rdata_d     = rdata_q;
        err_d       = err_q;

        lock_lost_d = (lock_hist_q & ~LOCK & (state_q != WAIT_LOCK))
                    | (lock_lost_q & ~lock_lost_clr);

        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    write_d     = cmd_write;
                    addr_d      = cmd_addr;
                    wdata_d     = cmd_wdata;
                    wait_lock_d = cmd_wait_lock;
                    busy_cnt_d  = '0;
                    rdata_d     = '0;
                    err_d       = ERR_OK;
                    state_d     = WAIT_BUSY;
                end
            end
            WAIT_BUSY: begin
                if (!BUSY) begin
                    state_d = SETUP;
                end else if (busy_cnt_q == BUSY_LAST) begin
                    err_d   = ERR_BUSY;
                    state_d = RESP;
                end else begin
                    busy_cnt_d = busy_cnt_q + 1'b1;
                end
            end
            SETUP: begin
                state_d = ACCESS;
            end
            ACCESS: begin
                if (!write_q) begin
                    rdata_d = PRDATA;
                end
                if (write_q && wait_lock_q) begin
                    lock_cnt_d = '0;
                    stable_d   = '0;
                    state_d    = WAIT_LOCK;
                end else begin
                    state_d = RESP;
                end
            end
            WAIT_LOCK: begin
                // Stable lock is tested before the timeout so a tie succeeds.
                if (LOCK && (stable_q == STABLE_LAST)) begin
                    err_d   = ERR_OK;
                    state_d = RESP;
                end else if (lock_cnt_q == LOCK_LAST) begin
                    err_d   = ERR_LOCK;
                    state_d = RESP;
                end else begin
                    lock_cnt_d = lock_cnt_q + 1'b1;
                    stable_d   = LOCK ? (stable_q + 1'b1) : '0;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs decode directly from the state register. cmd_ready is also
    // held low while reset is asserted so nothing is accepted during reset.
    always_comb begin
        cmd_ready = (state_q == IDLE) && PRESET_N;
        rsp_valid = 1'b0;
        rsp_rdata = '0;
        rsp_err   = ERR_OK;
        PSEL      = 1'b0;
        PENABLE   = 1'b0;
        PWRITE    = 1'b0;
        PADDR     = '0;
        PWDATA    = '0;
        lock_lost = lock_lost_q;

        if ((state_q == SETUP) || (state_q == ACCESS)) begin
            PSEL    = 1'b1;
            PENABLE = (state_q == ACCESS);
            PWRITE  = write_q;
            PADDR   = addr_q;
            PWDATA  = write_q ? wdata_q : '0;
        end

        if (state_q == RESP) begin
            rsp_valid = 1'b1;
            rsp_rdata = rdata_q;
            rsp_err   = err_q;
        end
    end

endmodule

// File: tb/tb_ccc_apb_cfg_master.sv
// tb_ccc_apb_cfg_master
//
// Self-checking bench for ccc_apb_cfg_master. A stimulus process issues
// commands and, for each one, works out from the block's rules the response
// it must produce (status, read data, and the clock edge on which the
// consumer sees it). A register-file reference and a LOCK pattern scan give
// those answers. A separate monitor pops the expectations whenever the DUT
// pulses rsp_valid or runs an APB access, and compares.
module tb_ccc_apb_cfg_master;

    localparam int ADDR_W  = 6;
    localparam int DATA_W  = 8;
    localparam int BUSY_TO = 256;
    localparam int LOCK_TO = 4096;
    localparam int LOCK_ST = 4;

    typedef struct {
        logic [1:0]        err;
        logic [DATA_W-1:0] rdata;
        int                rspEdge;
    } rsp_t;

    typedef struct {
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } apb_t;

    logic              PCLK;
    logic              PRESET_N;
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic              cmd_wait_lock;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic [1:0]        rsp_err;
    logic              lock_lost;
    logic              lock_lost_clr;
    logic              PSEL;
    logic              PENABLE;
    logic              PWRITE;
    logic [ADDR_W-1:0] PADDR;
    logic [DATA_W-1:0] PWDATA;
    logic [DATA_W-1:0] PRDATA;
    logic              BUSY;
    logic              LOCK;

    int testCount = 0;
    int failCount = 0;
    int cyc = 0;

    logic [DATA_W-1:0] refMem   [0:(1<<ADDR_W)-1];
    logic [DATA_W-1:0] slaveMem [0:(1<<ADDR_W)-1];
    logic              memLoad;
    bit                lockPat  [0:LOCK_TO-1];

    rsp_t rspQ[$];
    apb_t apbQ[$];
    bit   pendingRsp = 0;
    int   pendAccept = 0;

    rsp_t              monRsp;
    apb_t              monApb;
    bit                setupSeen = 0;
    logic [ADDR_W-1:0] setupAddr;

    ccc_apb_cfg_master #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BUSY_TIMEOUT(BUSY_TO),
        .LOCK_TIMEOUT(LOCK_TO), .LOCK_STABLE(LOCK_ST)
    ) dut (
        .PCLK(PCLK), .PRESET_N(PRESET_N),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wait_lock(cmd_wait_lock),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .lock_lost(lock_lost), .lock_lost_clr(lock_lost_clr),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
        .PWDATA(PWDATA), .PRDATA(PRDATA), .BUSY(BUSY), .LOCK(LOCK)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    // Edge counter: at a negedge, cyc is the index of the edge just passed.
    always @(posedge PCLK) cyc <= cyc + 1;

    // CCC register-file stand-in: preloaded from the reference during reset,
    // then updated only by real APB write accesses.
    always @(posedge PCLK) begin
        if (memLoad) begin
            for (int i = 0; i < (1 << ADDR_W); i++) slaveMem[i] <= refMem[i];
        end else if (PSEL && PENABLE && PWRITE) begin
            slaveMem[PADDR] <= PWDATA;
        end
    end
    assign PRDATA = slaveMem[PADDR];

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        testCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)",
                     name, actual, expected, cyc);
        end
    endtask

    // Outcome of a lock wait from the LOCK value seen on each WAIT_LOCK edge:
    // success on the first edge that completes LOCK_ST consecutive highs,
    // otherwise a timeout on the last permitted edge.
    function automatic int lockOutcome(output logic [1:0] err);
        int run = 0;
        for (int j = 0; j < LOCK_TO; j++) begin
            run = lockPat[j] ? run + 1 : 0;
            if (run >= LOCK_ST) begin
                err = 2'b00;
                return j;
            end
        end
        err = 2'b10;
        return LOCK_TO - 1;
    endfunction

    task automatic waitCyc(input int c);
        while (cyc < c) @(negedge PCLK);
    endtask

    // Issue one command, record what must come back, then drive BUSY for
    // busyN edges and, for a lock-waiting write, LOCK from lockPat.
    task automatic applyStimulus(input logic wr, input logic [ADDR_W-1:0] addr,
                                 input logic [DATA_W-1:0] wdata, input logic wl,
                                 input int busyN);
        int   guard = 0;
        int   t;
        int   j = 0;
        rsp_t e;
        while (cmd_ready !== 1'b1 && guard < 6000) begin
            @(negedge PCLK);
            guard++;
        end
        if (guard >= 6000) begin
            checkOutput("ready_wait_expired", {31'd0, cmd_ready}, 32'd1);
            return;
        end
        t = cyc + 1;
        cmd_valid     = 1'b1;
        cmd_write     = wr;
        cmd_addr      = addr;
        cmd_wdata     = wdata;
        cmd_wait_lock = wl;
        BUSY          = (busyN > 0);
        if (busyN >= BUSY_TO) begin
            e = '{err: 2'b01, rdata: '0, rspEdge: t + BUSY_TO + 1};
        end else begin
            apbQ.push_back('{wr: wr, addr: addr, wdata: wr ? wdata : '0});
            if (!wr) begin
                e = '{err: 2'b00, rdata: refMem[addr], rspEdge: t + busyN + 4};
            end else begin
                refMem[addr] = wdata;
                if (wl) begin
                    j = lockOutcome(e.err);
                    e.rdata   = '0;
                    e.rspEdge = t + busyN + 4 + j + 1;
                end else begin
                    e = '{err: 2'b00, rdata: '0, rspEdge: t + busyN + 4};
                end
            end
        end
        rspQ.push_back(e);
        pendAccept = t;
        pendingRsp = 1;
        @(negedge PCLK);
        cmd_valid = 1'b0;
        if (busyN > 0) begin
            waitCyc(t + busyN);
            BUSY = 1'b0;
        end
        if (wr && wl && busyN < BUSY_TO) begin
            waitCyc(t + busyN + 3);
            for (int k = 0; k <= j; k++) begin
                LOCK = lockPat[k];
                @(negedge PCLK);
            end
            LOCK = 1'b1;
        end
    endtask

    // Monitor: checks every response against the head of the expectation
    // queue, every APB access against the issued command, and that commands
    // are held off while one is outstanding.
    always @(negedge PCLK) begin
        if (rsp_valid === 1'b1) begin
            if (rspQ.size() == 0) begin
                checkOutput("rsp_unexpected", {31'd0, rsp_valid}, 32'd0);
            end else begin
                monRsp = rspQ.pop_front();
                checkOutput("rsp_err", {30'd0, rsp_err}, {30'd0, monRsp.err});
                checkOutput("rsp_rdata", {24'd0, rsp_rdata}, {24'd0, monRsp.rdata});
                checkOutput("rsp_edge", cyc + 1, monRsp.rspEdge);
                pendingRsp = 0;
            end
        end
        if (pendingRsp && cyc >= pendAccept && cmd_ready === 1'b1)
            checkOutput("ready_while_busy", {31'd0, cmd_ready}, 32'd0);
        if (PENABLE === 1'b1 && PSEL !== 1'b1)
            checkOutput("penable_without_psel", {31'd0, PSEL}, 32'd1);
        if (PSEL === 1'b1 && PENABLE === 1'b0) begin
            setupSeen = 1;
            setupAddr = PADDR;
        end
        if (PSEL === 1'b1 && PENABLE === 1'b1) begin
            if (apbQ.size() == 0) begin
                checkOutput("apb_unexpected", {31'd0, PSEL}, 32'd0);
            end else begin
                monApb = apbQ.pop_front();
                checkOutput("apb_setup_before_access", {31'd0, setupSeen}, 32'd1);
                checkOutput("apb_setup_addr", {26'd0, setupAddr}, {26'd0, monApb.addr});
                checkOutput("apb_pwrite", {31'd0, PWRITE}, {31'd0, monApb.wr});
                checkOutput("apb_paddr", {26'd0, PADDR}, {26'd0, monApb.addr});
                checkOutput("apb_pwdata", {24'd0, PWDATA}, {24'd0, monApb.wdata});
            end
            setupSeen = 0;
        end
    end

    initial begin
        #(10 * 95000);
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed checks first (reset, lock_lost, the documented scenarios and
    // boundaries), then randomized commands, then drain and summarize.
    initial begin
        logic              wr;
        logic              wl;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        int                busyN;
        int                plen;
        int                g;

        PRESET_N = 1'b0; memLoad = 1'b1;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        cmd_wait_lock = 1'b0; lock_lost_clr = 1'b0; BUSY = 1'b0; LOCK = 1'b1;
        for (int i = 0; i < (1 << ADDR_W); i++) refMem[i] = DATA_W'($urandom);
        refMem[6'h12] = 8'h3C;

        repeat (3) @(negedge PCLK);
        checkOutput("reset_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        checkOutput("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        checkOutput("reset_rsp_err", {30'd0, rsp_err}, 32'd0);
        checkOutput("reset_rsp_rdata", {24'd0, rsp_rdata}, 32'd0);
        checkOutput("reset_psel", {31'd0, PSEL}, 32'd0);
        checkOutput("reset_penable", {31'd0, PENABLE}, 32'd0);
        checkOutput("reset_pwrite", {31'd0, PWRITE}, 32'd0);
        checkOutput("reset_paddr", {26'd0, PADDR}, 32'd0);
        checkOutput("reset_pwdata", {24'd0, PWDATA}, 32'd0);
        checkOutput("reset_lock_lost", {31'd0, lock_lost}, 32'd0);
        memLoad = 1'b0;
        PRESET_N = 1'b1;
        @(negedge PCLK);
        checkOutput("ready_after_reset", {31'd0, cmd_ready}, 32'd1);

        // lock_lost: set on an idle LOCK fall, sticky, set beats clear.
        repeat (2) @(negedge PCLK);
        checkOutput("lock_lost_initial", {31'd0, lock_lost}, 32'd0);
        LOCK = 1'b0;
        @(negedge PCLK);
        checkOutput("lock_lost_set", {31'd0, lock_lost}, 32'd1);
        repeat (3) @(negedge PCLK);
        checkOutput("lock_lost_sticky", {31'd0, lock_lost}, 32'd1);
        LOCK = 1'b1;
        repeat (2) @(negedge PCLK);
        LOCK = 1'b0; lock_lost_clr = 1'b1;
        @(negedge PCLK);
        checkOutput("lock_lost_set_wins", {31'd0, lock_lost}, 32'd1);
        @(negedge PCLK);
        checkOutput("lock_lost_cleared", {31'd0, lock_lost}, 32'd0);
        lock_lost_clr = 1'b0; LOCK = 1'b1;
        repeat (2) @(negedge PCLK);
        checkOutput("lock_lost_stays_clear", {31'd0, lock_lost}, 32'd0);

        // Documented scenarios.
        applyStimulus(1'b1, 6'h05, 8'hA5, 1'b0, 0);
        applyStimulus(1'b0, 6'h12, 8'h00, 1'b0, 0);
        applyStimulus(1'b0, 6'h05, 8'h00, 1'b0, 10);
        applyStimulus(1'b1, 6'h21, 8'h77, 1'b0, BUSY_TO);
        applyStimulus(1'b0, 6'h21, 8'h00, 1'b0, 0);
        for (int i = 0; i < LOCK_TO; i++) lockPat[i] = !(i < 20 || (i >= 22 && i < 27));
        applyStimulus(1'b1, 6'h30, 8'h5A, 1'b1, 0);
        for (int i = 0; i < LOCK_TO; i++) lockPat[i] = 1'b0;
        applyStimulus(1'b1, 6'h31, 8'hC3, 1'b1, 0);
        for (int i = 0; i < LOCK_TO; i++) lockPat[i] = (i >= LOCK_TO - LOCK_ST);
        applyStimulus(1'b1, 6'h32, 8'h96, 1'b1, 3);

        // Reset during ACCESS: transfer dropped, no response, ready after release.
        g = 0;
        while (cmd_ready !== 1'b1 && g < 100) begin @(negedge PCLK); g++; end
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 6'h12; cmd_wait_lock = 1'b0;
        apbQ.push_back('{wr: 1'b0, addr: 6'h12, wdata: '0});
        @(negedge PCLK);
        cmd_valid = 1'b0;
        g = 0;
        while (!(PSEL === 1'b1 && PENABLE === 1'b1) && g < 10) begin @(negedge PCLK); g++; end
        checkOutput("reset_test_reached_access", {31'd0, PENABLE}, 32'd1);
        PRESET_N = 1'b0;
        @(negedge PCLK);
        checkOutput("midreset_psel", {31'd0, PSEL}, 32'd0);
        checkOutput("midreset_penable", {31'd0, PENABLE}, 32'd0);
        checkOutput("midreset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        checkOutput("midreset_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        @(negedge PCLK);
        PRESET_N = 1'b1;
        @(negedge PCLK);
        checkOutput("ready_after_midreset", {31'd0, cmd_ready}, 32'd1);
        repeat (3) @(negedge PCLK);
        checkOutput("no_rsp_after_midreset", {31'd0, rsp_valid}, 32'd0);

        // Randomized commands against the reference register file.
        for (int n = 0; n < 40; n++) begin
            repeat ($urandom_range(0, 3)) @(negedge PCLK);
            wr    = 1'($urandom_range(0, 1));
            addr  = ADDR_W'($urandom_range(0, (1 << ADDR_W) - 1));
            wdata = DATA_W'($urandom);
            wl    = wr && ($urandom_range(0, 1) == 1);
            if ($urandom_range(0, 9) < 6) busyN = 0;
            else if ($urandom_range(0, 19) == 0) busyN = BUSY_TO;
            else busyN = int'($urandom_range(1, 15));
            if (wl) begin
                plen = int'($urandom_range(0, 30));
                for (int i = 0; i < LOCK_TO; i++)
                    lockPat[i] = (i < plen) ? ($urandom_range(0, 1) == 1) : 1'b1;
            end
            applyStimulus(wr, addr, wdata, wl, busyN);
        end

        g = 0;
        while (rspQ.size() != 0 && g < 6000) begin @(negedge PCLK); g++; end
        checkOutput("all_responses_seen", rspQ.size(), 32'd0);
        checkOutput("all_apb_accesses_seen", apbQ.size(), 32'd0);
        checkOutput("lock_lost_quiet_in_wait_lock", {31'd0, lock_lost}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
